// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bus_pkg                                                   |
// | Brief    : Shared types and constants for the bus slave responder.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bus_reg_bank                                              |
// | Brief    : Word register bank, sync write, comb read, word 0 = ID.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module bus_reg_bank
  import bus_pkg::*;
#(
  parameter int                DWidth   = 32,
  parameter int                NumWords = 16,
  parameter logic [DWidth-1:0] IdValue  = 32'h5EED_0501
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_we,
  input  logic [idx_width(NumWords)-1:0]   i_widx,
  input  logic [DWidth-1:0]                i_wdata,
  input  logic [idx_width(NumWords)-1:0]   i_ridx,
  output logic [DWidth-1:0]                o_rdata
);

  logic [DWidth-1:0] r_mem [0:NumWords-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumWords; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_widx != '0)) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = (i_ridx == '0) ? IdValue : r_mem[i_ridx];

endmodule
`default_nettype wire

// File: rtl/bus_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bus_slave_responder                                       |
// | Brief    : Pipelined-bus slave with wait states and 2-cycle ERROR.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module bus_slave_responder
  import bus_pkg::*;
#(
  parameter int                DWidth     = 32,
  parameter int                NumWords   = 16,
  parameter int                WaitStates = 1,
  parameter logic [DWidth-1:0] IdValue    = 32'h5EED_0501
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_i,
  input  logic              trans_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  input  logic              ready_i,
  output logic [DWidth-1:0] rdata_o,
  output logic              resp_o,
  output logic              readyout_o
);

  localparam int c_IW = idx_width(NumWords);
  localparam int c_CW = idx_width(WaitStates + 1);

  state_e            r_state;
  state_e            w_next;
  logic [c_IW-1:0]   r_idx;
  logic [c_IW-1:0]   w_idx_nxt;
  logic [c_IW-1:0]   w_addr_idx;
  logic              r_write;
  logic              w_write_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic              w_accept;
  logic              w_err;
  logic              w_final;
  logic              w_bank_we;
  logic [DWidth-1:0] w_bank_rdata;

  assign w_addr_idx = addr_i[c_IW+1:2];
  assign w_accept   = sel_i & trans_i & ready_i;
  assign w_err      = (addr_i[1:0] != 2'b00) ||
                      ((addr_i >> (c_IW + 2)) != '0) ||
                      (write_i && (w_addr_idx == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      r_write <= w_write_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_idx_nxt   = r_idx;
    w_write_nxt = r_write;
    w_cnt_nxt   = r_cnt;
    w_final     = 1'b0;
    w_bank_we   = 1'b0;
    readyout_o  = 1'b1;
    resp_o      = RESP_OKAY;

    case (r_state)
      ST_IDLE: w_final = 1'b1;
      ST_WAIT: begin
        readyout_o = 1'b0;
        w_cnt_nxt  = r_cnt - 1'b1;
        if (r_cnt == c_CW'(1)) begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_final   = 1'b1;
        w_bank_we = r_write;
      end
      ST_ERR1: begin
        readyout_o = 1'b0;
        resp_o     = RESP_ERROR;
        w_next     = ST_ERR2;
      end
      ST_ERR2: begin
        resp_o  = RESP_ERROR;
        w_final = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase

    // The last data-phase cycle doubles as the next address phase.
    if (w_final) begin
      w_next = ST_IDLE;
      if (w_accept) begin
        w_idx_nxt   = w_addr_idx;
        w_write_nxt = write_i;
        if (w_err) begin
          w_next = ST_ERR1;
        end else if (WaitStates > 0) begin
          w_next    = ST_WAIT;
          w_cnt_nxt = c_CW'(WaitStates);
        end else begin
          w_next = ST_DATA;
        end
      end
    end
  end

  assign rdata_o = ((r_state == ST_DATA) && !r_write) ? w_bank_rdata : '0;

  bus_reg_bank #(
    .DWidth   (DWidth),
    .NumWords (NumWords),
    .IdValue  (IdValue)
  ) u_bank (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_we    (w_bank_we),
    .i_widx  (r_idx),
    .i_wdata (wdata_i),
    .i_ridx  (r_idx),
    .o_rdata (w_bank_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bus_slave_responder                                    |
// | Brief    : Two responders (0 and 1 wait states) vs transfer model.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_bus_slave_responder;

  localparam logic [31:0] c_ID = 32'h5EED_0501;

  typedef struct packed {
    logic       rdy;
    logic       resp;
    logic       rd;
    logic       wr;
    logic [3:0] idx;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel [2];
  logic        trans [2];
  logic        wr [2];
  logic        rdyf_en [2];
  logic        rdyf [2];
  logic        rdy [2];
  logic        resp [2];
  logic        ro [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];

  // Expected per-cycle outputs of the transfer in flight, one entry per cycle.
  ent_t        mq [2][$];
  logic [31:0] mem [2][16];
  logic [31:0] req_wd [2];
  logic [31:0] next_wd [2];
  logic [31:0] last_rd [2];
  bit          acc [2];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign rdy[0] = rdyf_en[0] ? rdyf[0] : ro[0];
  assign rdy[1] = rdyf_en[1] ? rdyf[1] : ro[1];

  bus_slave_responder #(.DWidth(32), .NumWords(16), .WaitStates(0), .IdValue(c_ID)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .sel_i(sel[0]), .trans_i(trans[0]), .write_i(wr[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_i(rdy[0]),
    .rdata_o(rdata[0]), .resp_o(resp[0]), .readyout_o(ro[0])
  );

  bus_slave_responder #(.DWidth(32), .NumWords(16), .WaitStates(1), .IdValue(c_ID)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .sel_i(sel[1]), .trans_i(trans[1]), .write_i(wr[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_i(rdy[1]),
    .rdata_o(rdata[1]), .resp_o(resp[1]), .readyout_o(ro[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic ent_t mk(input logic r, input logic s, input logic rd, input logic w,
                              input logic [3:0] idx);
    ent_t e;
    e.rdy = r; e.resp = s; e.rd = rd; e.wr = w; e.idx = idx;
    return e;
  endfunction

  // Check outputs at negedge, advance the model at posedge, drive at posedge+1.
  task automatic step();
    logic        c_go [2];
    logic        c_wr [2];
    logic [31:0] c_addr [2];
    logic [31:0] c_wd [2];
    logic        c_rst;
    logic        e_rdy, e_resp;
    logic [31:0] e_data;
    ent_t        e;
    bit          can, bad;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
      if (mq[d].size() > 0) begin
        e = mq[d][0];
        e_rdy = e.rdy; e_resp = e.resp;
        if (e.rd) begin
          e_data = (e.idx == 4'd0) ? c_ID : mem[d][e.idx];
          last_rd[d] = rdata[d];
        end
      end
      chk($sformatf("d%0d_readyout", d), {31'b0, ro[d]}, {31'b0, e_rdy});
      chk($sformatf("d%0d_resp", d), {31'b0, resp[d]}, {31'b0, e_resp});
      chk($sformatf("d%0d_rdata", d), rdata[d], e_data);
      c_go[d]   = sel[d] & trans[d] & rdy[d];
      c_wr[d]   = wr[d];
      c_addr[d] = addr[d];
      c_wd[d]   = wdata[d];
    end
    c_rst = rst;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d] = 1'b0;
      if (c_rst) begin
        mq[d].delete();
        for (int i = 0; i < 16; i++) mem[d][i] = '0;
      end else begin
        can = (mq[d].size() <= 1);
        if (mq[d].size() > 0) begin
          e = mq[d].pop_front();
          if (e.wr) mem[d][e.idx] = c_wd[d];
        end
        if (can && c_go[d]) begin
          acc[d] = 1'b1;
          bad = (c_addr[d] % 4 != 0) || (c_addr[d] / 4 >= 16) || (c_wr[d] && (c_addr[d] / 4 == 0));
          if (bad) begin
            mq[d].push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
            mq[d].push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
          end else begin
            for (int k = 0; k < d; k++) mq[d].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
            mq[d].push_back(mk(1'b1, 1'b0, !c_wr[d], c_wr[d], c_addr[d][5:2]));
            if (c_wr[d]) next_wd[d] = req_wd[d];
          end
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) wdata[d] = next_wd[d];
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic addr_phase(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    sel[d] = 1'b1; trans[d] = 1'b1; wr[d] = w; addr[d] = a; req_wd[d] = wd;
    do begin
      step();
      n++;
    end while (!acc[d] && n < 20);
    chk($sformatf("d%0d_accept", d), {31'b0, acc[d]}, 32'd1);
    sel[d] = 1'b0; trans[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      sel[d] = 0; trans[d] = 0; wr[d] = 0; addr[d] = 0; wdata[d] = 0;
      rdyf_en[d] = 0; rdyf[d] = 0; req_wd[d] = 0; next_wd[d] = 0; last_rd[d] = '1;
      for (int i = 0; i < 16; i++) mem[d][i] = '0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;

    addr_phase(1, 1'b0, 32'h4, 0); idle(3);
    chk("reset_read", last_rd[1], 32'h0);

    addr_phase(1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    addr_phase(1, 1'b0, 32'h8, 0); idle(3);
    chk("raw_read", last_rd[1], 32'hDEAD_BEEF);

    addr_phase(1, 1'b0, 32'h6, 0); idle(3);
    addr_phase(1, 1'b0, 32'h40, 0); idle(3);
    addr_phase(1, 1'b1, 32'h0, 32'h1234);
    addr_phase(1, 1'b0, 32'h0, 0); idle(3);
    chk("id_read", last_rd[1], c_ID);

    rdyf_en[1] = 1'b1; rdyf[1] = 1'b0;
    sel[1] = 1'b1; trans[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h8;
    repeat (3) begin
      step();
      chk("no_accept_ready_low", {31'b0, acc[1]}, 32'd0);
    end
    rdyf[1] = 1'b1;
    step();
    chk("accept_ready_rise", {31'b0, acc[1]}, 32'd1);
    sel[1] = 1'b0; trans[1] = 1'b0; rdyf_en[1] = 1'b0;
    idle(3);

    addr_phase(0, 1'b1, 32'h4, 32'd1);
    addr_phase(0, 1'b1, 32'h8, 32'd2);
    addr_phase(0, 1'b1, 32'hC, 32'd3);
    addr_phase(0, 1'b0, 32'h4, 0);
    addr_phase(0, 1'b0, 32'h8, 0);
    addr_phase(0, 1'b0, 32'hC, 0);
    idle(2);
    chk("stream_last", last_rd[0], 32'd3);

    addr_phase(1, 1'b1, 32'hC, 32'hAAAA_5555);
    rst = 1'b1; step(); rst = 1'b0; step();
    addr_phase(1, 1'b0, 32'hC, 0); idle(3);
    chk("reset_abort", last_rd[1], 32'h0);

    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        sel[d]   = ($urandom_range(0, 3) != 0);
        trans[d] = ($urandom_range(0, 3) != 0);
        wr[d]    = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 9))
          0:       addr[d] = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
          1:       addr[d] = $urandom;
          2:       addr[d] = 32'h0;
          default: addr[d] = $urandom_range(0, 15) << 2;
        endcase
        req_wd[d]  = $urandom;
        rdyf_en[d] = ($urandom_range(0, 7) == 0);
        rdyf[d]    = 1'b0;
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sel[d] = 0; trans[d] = 0; rdyf_en[d] = 0;
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_slave_responder.md
Name: bus_slave_responder

Overview:
- Slave-side responder for the team's single-master pipelined bus: the other end of the decoder/mux interconnect.
- Consumes the interconnect's per-slave select plus the master's address-phase signals.
- Runs the data phase against an internal word-addressed register bank with a parameterised number of wait states.
- Drives the rdata/resp/readyout triple that the interconnect mux returns to the master, including the two-cycle error response.

Parameters:
DWidth, 32, data and address width
NumWords, 16, register bank depth in words; word 0 is a read-only ID register
WaitStates, 1, stall cycles inserted in every OKAY data phase (0 = zero-wait)
IdValue, 32'h5EED_0501, constant returned by reads of word 0

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, synchronous, active-high
sel_i  input  1  slave select from interconnect decoder
trans_i  input  1  master drives a valid transfer this address phase
write_i  input  1  1 = write, 0 = read (address phase)
addr_i  input  DWidth  byte address (address phase); slave uses offset bits only
wdata_i  input  DWidth  write data (data phase, one cycle after address phase)
ready_i  input  1  bus-level ready from interconnect mux (previous transfer completing)
rdata_o  output  DWidth  read data, valid when readyout_o=1 in an OKAY read data phase, else 0
resp_o  output  1  0 = OKAY, 1 = ERROR
readyout_o  output  1  0 = stall current data phase

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE, readyout_o=1, resp_o=0, rdata_o=0, wait counter=0, bank words 1..NumWords-1 cleared to 0. Reset mid-transfer aborts it; no write commits.
- Address phase accepted iff sel_i & trans_i & ready_i at a clock edge. Latch word index = addr_i[$clog2(NumWords)+1:2] and write_i. Otherwise no transfer; IDLE outputs readyout_o=1, resp_o=0.
- Error decode at acceptance:
  - addr_i[1:0]!=0, or
  - addr_i bits above the index field nonzero (index >= NumWords), or
  - write to index 0.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE -> ERR1 on accepted error. IDLE -> WAIT on accepted OK when WaitStates>0, counter loaded to WaitStates. Otherwise IDLE -> DATA.
- WAIT: readyout_o=0, resp_o=0; counter decrements each cycle; -> DATA when counter reaches 1.
- DATA: readyout_o=1, resp_o=0.
  - Read: rdata_o = bank[index], or IdValue for index 0.
  - Write: bank[index] <= wdata_i at the end of this cycle.
- ERR1: readyout_o=0, resp_o=1. Always -> ERR2.
- ERR2: readyout_o=1, resp_o=1. No bank change.
- Leaving DATA or ERR2 (the final data-phase cycle): if a new address phase is accepted in the same cycle (pipelined back-to-back), branch exactly as from IDLE; else -> IDLE.
- Latency: OKAY transfer completes WaitStates+1 cycles after the address-phase edge; ERROR completes 2 cycles after.
- Read-after-write to the same word back-to-back returns the new data, since the write commits before the read data phase.
- While ready_i=0 (another slave stalling), sel_i/trans_i are ignored; no acceptance.
- wdata_i is sampled only in the DATA cycle of a write.

Decomposition:
- Shared package bus_pkg:
  - state enum typedef.
  - constants RESP_OKAY=1'b0 and RESP_ERROR=1'b1.
  - localparam function for index width.
- One natural sub-module: bus_reg_bank.
  - NumWords x DWidth.
  - Synchronous write enable/index/data, combinational read, word 0 hardwired to IdValue.
  - Synchronous clear on rst_i.

Test Plan:
- Reset: rst_i=1 for 2 cycles -> readyout_o=1, resp_o=0, rdata_o=0; then read addr 0x4 -> 0x0000_0000.
- WaitStates=1, write 0xDEAD_BEEF to 0x8, then read 0x8 back-to-back -> write stalls exactly 1 cycle (readyout_o=0), read returns 0xDEAD_BEEF with resp_o=0.
- Error cases -> ERR1 (readyout_o=0, resp_o=1) then ERR2 (readyout_o=1, resp_o=1):
  - read of 0x6 (misaligned);
  - read of 0x40 with NumWords=16 (out of range);
  - write 0x1234 to 0x0, after which a read of 0x0 returns 0x5EED_0501.
- ready_i=0 with sel_i=trans_i=1 for 3 cycles -> no acceptance, outputs stay idle (1/0/0); accepted on the cycle ready_i rises.
- WaitStates=0 pipelined stream of reads of 0x4, 0x8, 0xC after writing 1, 2, 3 -> readyout_o held 1, rdata_o=1, 2, 3 on consecutive cycles.
- rst_i asserted during WAIT of a write of 0xAAAA_5555 to 0xC -> next cycle outputs 1/0/0, a subsequent read of 0xC returns 0.
